// File: rtl/arb_pkg.sv
// Shared arbitration types: master ID width and the default master count.
// The round-robin arbiter's binary grant output uses the same ID type.
package arb_pkg;

   localparam int ARB_WIDTH     = 4;
   localparam int ARB_BIN_WIDTH = $clog2(ARB_WIDTH);

   typedef logic [ARB_BIN_WIDTH-1:0] mst_id_t;

endpackage

// File: rtl/id_fifo.sv
// In-order FIFO of master IDs. Only the pointers and the count are reset.
// The storage is left unreset because the count alone decides which entries are valid.
// The caller must never push while full unless it also pops.
// The caller must never pop while empty.
module id_fifo #(
   parameter int Depth = 4,
   parameter int DataW = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic [DataW-1:0]             data_i,
   output logic [DataW-1:0]             data_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(Depth+1)-1:0]   count_o
);

   localparam int PtrW = $clog2(Depth);
   localparam int CntW = $clog2(Depth+1);

   logic [DataW-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;

   // Next-state for the pointers and the occupancy count.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/rsp_router.sv
// Response-return demux. Records the grant ID of each accepted request.
// Steers every slave response back to the master at the head of the ID FIFO.
// Orphan responses are drained so that the slave never stalls.
module rsp_router
   import arb_pkg::*;
#(
   parameter int Width     = ARB_WIDTH,
   parameter int DataWidth = 32,
   parameter int Depth     = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_fire_i,
   input  logic [$clog2(Width)-1:0]      req_id_i,
   output logic                          outstanding_full_o,
   input  logic                          rsp_valid_i,
   output logic                          rsp_ready_o,
   input  logic [DataWidth-1:0]          rsp_data_i,
   input  logic                          rsp_err_i,
   output logic [Width-1:0]              mst_rsp_valid_o,
   input  logic [Width-1:0]              mst_rsp_ready_i,
   output logic [DataWidth-1:0]          mst_rsp_data_o,
   output logic                          mst_rsp_err_o,
   output logic                          idle_o,
   output logic                          proto_err_o
);

   localparam int BinWidth = $clog2(Width);
   localparam int CntWidth = $clog2(Depth+1);

   logic [BinWidth-1:0] head_id;
   logic                fifo_full;
   logic                fifo_empty;
   logic [CntWidth-1:0] fifo_count;
   logic                push;
   logic                pop;
   logic                head_ok;
   logic                proto_err_q, proto_err_d;

   id_fifo #(
      .Depth (Depth),
      .DataW (BinWidth)
   ) u_id_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (req_id_i),
      .data_o  (head_id),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Route the response to the head master. An empty FIFO, or a head ID with no matching master, drains the response.
   always_comb begin
      mst_rsp_valid_o = '0;
      rsp_ready_o     = 1'b1;
      head_ok         = 1'b0;
      if (!fifo_empty) begin
         for (int i = 0; i < Width; i++) begin
            if (head_id == BinWidth'(i)) begin
               head_ok            = 1'b1;
               mst_rsp_valid_o[i] = rsp_valid_i;
               rsp_ready_o        = mst_rsp_ready_i[i];
            end
         end
      end
   end

   // A pop frees its slot in the same cycle, so a push while full is accepted when it coincides with a pop.
   always_comb begin
      pop  = rsp_valid_i & rsp_ready_o & ~fifo_empty;
      push = req_fire_i & (~fifo_full | pop);
   end

   // Sticky error: orphan response, dropped request, or an out-of-range ID reaching the head.
   always_comb begin
      proto_err_d = proto_err_q
                  | (rsp_valid_i & fifo_empty)
                  | (req_fire_i & fifo_full & ~pop)
                  | (rsp_valid_i & ~fifo_empty & ~head_ok);
   end

   // Sticky error register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) proto_err_q <= 1'b0;
      else        proto_err_q <= proto_err_d;
   end

   assign mst_rsp_data_o     = rsp_data_i;
   assign mst_rsp_err_o      = rsp_err_i;
   assign outstanding_full_o = (fifo_count == CntWidth'(Depth));
   assign idle_o             = (fifo_count == '0);
   assign proto_err_o        = proto_err_q;

endmodule

// File: tb/tb_rsp_router.sv
// Directed bench for rsp_router. Routed handshakes are checked by a scoreboard monitor.
// Status flags and drain behaviour are checked inline.
module tb_rsp_router;

   logic        clk;
   logic        rst_n;
   logic        req_fire_i;
   logic [1:0]  req_id_i;
   logic        outstanding_full_o;
   logic        rsp_valid_i;
   logic        rsp_ready_o;
   logic [31:0] rsp_data_i;
   logic        rsp_err_i;
   logic [3:0]  mst_rsp_valid_o;
   logic [3:0]  mst_rsp_ready_i;
   logic [31:0] mst_rsp_data_o;
   logic        mst_rsp_err_o;
   logic        idle_o;
   logic        proto_err_o;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [3:0]  vld;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t exp_q[$];

   rsp_router #(.Width(4), .DataWidth(32), .Depth(4)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .req_fire_i         (req_fire_i),
      .req_id_i           (req_id_i),
      .outstanding_full_o (outstanding_full_o),
      .rsp_valid_i        (rsp_valid_i),
      .rsp_ready_o        (rsp_ready_o),
      .rsp_data_i         (rsp_data_i),
      .rsp_err_i          (rsp_err_i),
      .mst_rsp_valid_o    (mst_rsp_valid_o),
      .mst_rsp_ready_i    (mst_rsp_ready_i),
      .mst_rsp_data_o     (mst_rsp_data_o),
      .mst_rsp_err_o      (mst_rsp_err_o),
      .idle_o             (idle_o),
      .proto_err_o        (proto_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every completed master handshake must match the oldest expected response.
   always @(negedge clk) begin
      if (rst_n && ((mst_rsp_valid_o & mst_rsp_ready_i) != 4'b0)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_handshake", {28'b0, mst_rsp_valid_o}, 32'h0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("route_valid", {28'b0, mst_rsp_valid_o}, {28'b0, e.vld});
            chk("route_data",  mst_rsp_data_o, e.data);
            chk("route_err",   {31'b0, mst_rsp_err_o}, {31'b0, e.err});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_id(input logic [1:0] id);
      req_fire_i = 1'b1;
      req_id_i   = id;
      tick();
      req_fire_i = 1'b0;
   endtask

   // Present one response that is expected to reach master id with the given ready mask.
   task automatic respond(input int id, input logic [31:0] data, input logic err, input logic [3:0] rdy);
      exp_t e;
      logic [3:0] one;
      one        = 4'b0001;
      e.vld      = one << id;
      e.data     = data;
      e.err      = err;
      exp_q.push_back(e);
      rsp_valid_i     = 1'b1;
      rsp_data_i      = data;
      rsp_err_i       = err;
      mst_rsp_ready_i = rdy;
      tick();
      rsp_valid_i     = 1'b0;
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #3 rst_n = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n           = 1'b0;
      req_fire_i      = 1'b0;
      req_id_i        = 2'd0;
      rsp_valid_i     = 1'b0;
      rsp_data_i      = 32'h0;
      rsp_err_i       = 1'b0;
      mst_rsp_ready_i = 4'b0;
      #12;
      chk("rst_idle",  {31'b0, idle_o}, 32'd1);
      chk("rst_full",  {31'b0, outstanding_full_o}, 32'd0);
      chk("rst_perr",  {31'b0, proto_err_o}, 32'd0);
      chk("rst_valid", {28'b0, mst_rsp_valid_o}, 32'd0);
      chk("rst_ready", {31'b0, rsp_ready_o}, 32'd1);
      rst_n = 1'b1;
      tick();

      // single transaction
      push_id(2'd2);
      chk("single_not_idle", {31'b0, idle_o}, 32'd0);
      respond(2, 32'hDEADBEEF, 1'b0, 4'b0100);
      chk("single_idle_after", {31'b0, idle_o}, 32'd1);

      // in-order fill
      push_id(2'd1);
      push_id(2'd3);
      push_id(2'd0);
      push_id(2'd2);
      chk("fill_full", {31'b0, outstanding_full_o}, 32'd1);
      respond(1, 32'h1111_0001, 1'b0, 4'b1111);
      chk("fill_not_full", {31'b0, outstanding_full_o}, 32'd0);
      respond(3, 32'h3333_0002, 1'b1, 4'b1111);
      respond(0, 32'h0000_0003, 1'b0, 4'b1111);
      respond(2, 32'h2222_0004, 1'b1, 4'b1111);
      chk("fill_idle", {31'b0, idle_o}, 32'd1);

      // backpressure
      push_id(2'd3);
      push_id(2'd1);
      rsp_valid_i     = 1'b1;
      rsp_data_i      = 32'hCAFE_0003;
      rsp_err_i       = 1'b0;
      mst_rsp_ready_i = 4'b0111;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_ready_low", {31'b0, rsp_ready_o}, 32'd0);
         chk("bp_valid",     {28'b0, mst_rsp_valid_o}, 32'h8);
         tick();
      end
      chk("bp_no_pop_idle", {31'b0, idle_o}, 32'd0);
      respond(3, 32'hCAFE_0003, 1'b0, 4'b1000);
      chk("bp_one_left", {31'b0, idle_o}, 32'd0);
      respond(1, 32'hCAFE_0001, 1'b0, 4'b0010);
      chk("bp_idle", {31'b0, idle_o}, 32'd1);

      // full with simultaneous push and pop
      push_id(2'd0);
      push_id(2'd1);
      push_id(2'd2);
      push_id(2'd3);
      req_fire_i = 1'b1;
      req_id_i   = 2'd1;
      respond(0, 32'hA000_0000, 1'b0, 4'b1111);
      req_fire_i = 1'b0;
      chk("pp_still_full", {31'b0, outstanding_full_o}, 32'd1);
      respond(1, 32'hA000_0001, 1'b0, 4'b1111);
      respond(2, 32'hA000_0002, 1'b0, 4'b1111);
      respond(3, 32'hA000_0003, 1'b0, 4'b1111);
      chk("pp_not_idle", {31'b0, idle_o}, 32'd0);
      respond(1, 32'hA000_0011, 1'b1, 4'b1111);
      chk("pp_idle", {31'b0, idle_o}, 32'd1);
      chk("pp_no_perr", {31'b0, proto_err_o}, 32'd0);

      // orphan response
      rsp_valid_i     = 1'b1;
      rsp_data_i      = 32'h0BAD_0BAD;
      mst_rsp_ready_i = 4'b0000;
      #1;
      chk("orphan_ready", {31'b0, rsp_ready_o}, 32'd1);
      chk("orphan_valid", {28'b0, mst_rsp_valid_o}, 32'd0);
      chk("orphan_perr_before", {31'b0, proto_err_o}, 32'd0);
      tick();
      rsp_valid_i = 1'b0;
      chk("orphan_perr", {31'b0, proto_err_o}, 32'd1);
      apply_reset();
      chk("perr_cleared", {31'b0, proto_err_o}, 32'd0);

      // push while full with no pop: ID dropped
      push_id(2'd0);
      push_id(2'd1);
      push_id(2'd2);
      push_id(2'd3);
      chk("ovf_no_perr_yet", {31'b0, proto_err_o}, 32'd0);
      push_id(2'd2);
      chk("ovf_perr", {31'b0, proto_err_o}, 32'd1);
      chk("ovf_full", {31'b0, outstanding_full_o}, 32'd1);
      respond(0, 32'hB000_0000, 1'b0, 4'b1111);
      respond(1, 32'hB000_0001, 1'b0, 4'b1111);
      respond(2, 32'hB000_0002, 1'b0, 4'b1111);
      respond(3, 32'hB000_0003, 1'b0, 4'b1111);
      chk("ovf_dropped_idle", {31'b0, idle_o}, 32'd1);
      apply_reset();

      // asynchronous reset mid-operation
      push_id(2'd1);
      push_id(2'd2);
      push_id(2'd3);
      chk("mid_not_idle", {31'b0, idle_o}, 32'd0);
      mst_rsp_ready_i = 4'b0000;
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_idle",  {31'b0, idle_o}, 32'd1);
      chk("mid_rst_full",  {31'b0, outstanding_full_o}, 32'd0);
      chk("mid_rst_perr",  {31'b0, proto_err_o}, 32'd0);
      chk("mid_rst_valid", {28'b0, mst_rsp_valid_o}, 32'd0);
      chk("mid_rst_ready", {31'b0, rsp_ready_o}, 32'd1);
      @(negedge clk);
      #1 rst_n = 1'b1;
      tick();
      rsp_valid_i = 1'b1;
      #1;
      chk("post_rst_orphan_valid", {28'b0, mst_rsp_valid_o}, 32'd0);
      tick();
      rsp_valid_i = 1'b0;
      chk("post_rst_orphan_perr", {31'b0, proto_err_o}, 32'd1);

      tick();
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
